instruction_executor: RTL and testbench
=======================================

# instruction_executor

Consumes the 32-bit instruction words emitted by the instruction decoder and turns them into framebuffer pixel writes for the VGA GPU. It holds the drawing state: the current colour and a cursor. It runs multi-pixel operations as a write-port handshake toward framebuffer memory. It sits between the decoder's instruction output and the framebuffer write port, and reports busy so the host side can pace instruction traffic.

## Interface
- H_RES, 640: horizontal resolution, in pixels.
- V_RES, 480: vertical resolution, in lines.
- ADDR_W, 19: framebuffer address width; must satisfy H_RES*V_RES <= 2**ADDR_W.
- COLOR_W, 8: pixel width.
- i_clk  input  1  sole clock; all logic is on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_instruction  input  32  instruction word: [7:0] opcode, [31:8] args.
- i_instruction_ready  input  1  one-cycle pulse; i_instruction is valid in that cycle.
- o_busy  output  1  high while a pixel-writing operation is in progress.
- o_fb_we  output  1  write request; held high until acknowledged.
- o_fb_addr  output  ADDR_W  linear pixel address, y*H_RES+x.
- o_fb_data  output  COLOR_W  pixel value.
- i_fb_ack  input  1  framebuffer accepts the current write in this cycle.
- o_error  output  1  sticky flag: unknown opcode or out-of-range cursor.
- o_overrun  output  1  sticky flag: an instruction arrived while busy and was dropped.

## Operation
- Opcodes are listed below.
  - 0x00 NOP: no effect.
  - 0x01 SET_COLOR: color <= args[COLOR_W-1:0].
  - 0x02 SET_CURSOR: x = args[11:0], y = args[23:12].
    - If x >= H_RES or y >= V_RES, the instruction is ignored and o_error is set.
  - 0x03 PUT_PIXEL: writes one pixel with the current colour at the cursor, then advances the cursor.
  - 0x04 FILL_RUN: writes N = args[15:0] pixels of the current colour, starting at the cursor and advancing after each pixel.
    - N=0 performs no write.
  - 0x05 CLEAR: writes args[COLOR_W-1:0] to all H_RES*V_RES pixels from address 0.
    - The cursor ends at (0,0).
    - The current colour is unchanged.
  - Any other opcode: treated as NOP and sets o_error.
- Cursor advance:
  - x+1, and address+1.
  - At x=H_RES-1, x becomes 0 and y becomes y+1.
  - At (H_RES-1, V_RES-1), x, y and the address all become 0.
  - The address is tracked incrementally. The multiply y*H_RES+x is used only by SET_CURSOR.
- The state machine has two states, IDLE and WRITE.
  - IDLE with a pulse and a register-only opcode (NOP, SET_COLOR, SET_CURSOR, FILL_RUN with N=0, unknown): update state and stay in IDLE.
  - IDLE with a pulse and a pixel opcode: load the remaining count and go to WRITE.
    - PUT_PIXEL loads 1.
    - FILL_RUN loads N.
    - CLEAR loads H_RES*V_RES.
  - WRITE, cycle with i_fb_ack: advance the cursor and decrement the count. When the count reaches 0, go to IDLE.
- The remaining counter is max(16, ADDR_W+1) bits wide.
- o_busy = (state == WRITE).
- i_instruction_ready while in WRITE: the instruction is dropped and o_overrun is set. The operation in progress is unaffected.
- o_error and o_overrun clear only on i_reset.

## Timing
- Reset values:
  - All outputs are 0.
  - Colour 0, cursor (0,0), state IDLE.
- Register-only opcodes take effect on the clock edge of the pulse cycle. A pixel opcode may follow in the very next cycle.
- Pixel opcodes:
  - o_fb_we, o_fb_addr and o_fb_data are valid registered outputs in the cycle after the pulse.
  - o_busy rises in that same cycle.
- The write handshake:
  - A write completes in a cycle where o_fb_we && i_fb_ack.
  - o_fb_addr and o_fb_data stay stable while o_fb_we is high and unacknowledged.
  - With i_fb_ack held high, throughput is one pixel per cycle.
  - Pulses of i_fb_ack while o_fb_we is low are ignored.
- After the final ack, o_fb_we and o_busy are low in the next cycle.
- The cycle after the final ack is IDLE and accepts a new instruction.
- i_reset asserted mid-operation:
  - o_fb_we drops immediately, asynchronously.
  - The count is discarded and the cursor returns to (0,0).

## Configuration
- EXECUTOR_CLEAR_EN defined: opcode 0x05 CLEAR is implemented as specified.
- EXECUTOR_CLEAR_EN undefined:
  - 0x05 is an unknown opcode: NOP and o_error.
  - The full-screen count constant and its load path are removed.

## Structure
- Package gpu_pkg holds:
  - the opcode localparams (OP_NOP through OP_CLEAR);
  - the state enum (IDLE, WRITE);
  - the argument field positions (CURSOR_X_LSB=0, CURSOR_Y_LSB=12, RUN_LEN_W=16).
- Sub-module gpu_cursor holds x, y and the linear address, with load (x, y) and advance inputs and the wrap logic. Reset sets it to (0,0,0).

## Test plan
- After reset, SET_COLOR 0x2A; SET_CURSOR x=5, y=2; PUT_PIXEL with ack tied high -> exactly one write, addr 1285, data 0x2A; o_busy high for 1 cycle.
- SET_CURSOR (638,479); FILL_RUN N=3 with ack high -> addrs 307198, 307199, 0 on consecutive cycles; final cursor (1,0).
- FILL_RUN N=4 with i_fb_ack low for 3 cycles before each ack -> addr and data held stable while unacknowledged; exactly 4 writes; o_busy high 16 cycles.
- PUT_PIXEL pulse during a FILL_RUN -> o_overrun=1; write count unchanged; SET_CURSOR x=640 -> ignored, o_error=1; opcode 0x7F -> o_error=1.
- CLEAR 0x11, with EXECUTOR_CLEAR_EN defined -> 307200 writes of 0x11 to addrs 0..307199, cursor (0,0); without the macro -> no writes, o_error=1.
- i_reset asserted mid-FILL_RUN -> o_fb_we low immediately; after release, PUT_PIXEL writes addr 0, data 0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared opcodes, FSM state and instruction field layout for the GPU pixel path.
// Consumers: gpu_cursor, instruction_executor.
package gpu_pkg;

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_SET_COLOR  = 8'h01;
  localparam logic [7:0] OP_SET_CURSOR = 8'h02;
  localparam logic [7:0] OP_PUT_PIXEL  = 8'h03;
  localparam logic [7:0] OP_FILL_RUN   = 8'h04;
  localparam logic [7:0] OP_CLEAR      = 8'h05;

  localparam int CURSOR_X_LSB = 0;
  localparam int CURSOR_Y_LSB = 12;
  localparam int COORD_W      = 12;
  localparam int RUN_LEN_W    = 16;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gpu_cursor.sv
// Drawing cursor: (x, y) plus the matching linear framebuffer address.
// Loading multiplies once; advancing keeps the address in step incrementally.
module gpu_cursor
  import gpu_pkg::*;
#(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic               advance,
  output logic [ADDR_W-1:0]  addr
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);
  localparam logic [COORD_W-1:0] X_ONE  = COORD_W'(1);
  localparam logic [ADDR_W-1:0]  A_ONE  = ADDR_W'(1);

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [ADDR_W-1:0]  load_addr;

  assign load_addr = ADDR_W'(load_y) * ADDR_W'(H_RES) + ADDR_W'(load_x);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (load) begin
      x    <= load_x;
      y    <= load_y;
      addr <= load_addr;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        if (y == Y_LAST) begin
          // Last pixel of the frame wraps everything back to the origin.
          y    <= '0;
          addr <= '0;
        end else begin
          y    <= y + X_ONE;
          addr <= addr + A_ONE;
        end
      end else begin
        x    <= x + X_ONE;
        addr <= addr + A_ONE;
      end
    end
  end

endmodule

// File: rtl/instruction_executor.sv
// Turns decoded GPU instructions into framebuffer pixel writes with a we/ack handshake.
// Optional full-screen CLEAR (opcode 0x05) is built only when EXECUTOR_CLEAR_EN is defined.
module instruction_executor
  import gpu_pkg::*;
#(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [31:0]        i_instruction,
  input  logic               i_instruction_ready,
  output logic               o_busy,
  output logic               o_fb_we,
  output logic [ADDR_W-1:0]  o_fb_addr,
  output logic [COLOR_W-1:0] o_fb_data,
  input  logic               i_fb_ack,
  output logic               o_error,
  output logic               o_overrun
);

  localparam int CNT_W = max_int(16, ADDR_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef EXECUTOR_CLEAR_EN
  localparam logic [CNT_W-1:0] FULL_SCREEN = CNT_W'(H_RES * V_RES);
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [COLOR_W-1:0] pix_q, pix_d;
  logic               error_q, error_d;
  logic               overrun_q, overrun_d;

  logic               cur_load;
  logic               cur_advance;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;

  logic [7:0]           opcode;
  logic [23:0]          args;
  logic [COORD_W-1:0]   arg_x;
  logic [COORD_W-1:0]   arg_y;
  logic [RUN_LEN_W-1:0] run_len;

  assign opcode  = i_instruction[7:0];
  assign args    = i_instruction[31:8];
  assign arg_x   = args[CURSOR_X_LSB +: COORD_W];
  assign arg_y   = args[CURSOR_Y_LSB +: COORD_W];
  assign run_len = args[RUN_LEN_W-1:0];

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    color_d     = color_q;
    pix_d       = pix_q;
    error_d     = error_q;
    overrun_d   = overrun_q;
    cur_load    = 1'b0;
    cur_advance = 1'b0;
    cur_x       = '0;
    cur_y       = '0;

    case (state_q)
      IDLE: begin
        if (i_instruction_ready) begin
          case (opcode)
            OP_NOP: ;
            OP_SET_COLOR: color_d = args[COLOR_W-1:0];
            OP_SET_CURSOR: begin
              if (int'(arg_x) >= H_RES || int'(arg_y) >= V_RES) begin
                error_d = 1'b1;
              end else begin
                cur_load = 1'b1;
                cur_x    = arg_x;
                cur_y    = arg_y;
              end
            end
            OP_PUT_PIXEL: begin
              count_d = CNT_ONE;
              pix_d   = color_q;
              state_d = WRITE;
            end
            OP_FILL_RUN: begin
              if (run_len != '0) begin
                count_d = CNT_W'(run_len);
                pix_d   = color_q;
                state_d = WRITE;
              end
            end
`ifdef EXECUTOR_CLEAR_EN
            OP_CLEAR: begin
              // Rewind to the origin; the frame-length run wraps it back there at the end.
              count_d  = FULL_SCREEN;
              pix_d    = args[COLOR_W-1:0];
              cur_load = 1'b1;
              state_d  = WRITE;
            end
`endif
            default: error_d = 1'b1;
          endcase
        end
      end
      WRITE: begin
        if (i_instruction_ready) overrun_d = 1'b1;
        if (i_fb_ack) begin
          cur_advance = 1'b1;
          count_d     = count_q - CNT_ONE;
          if (count_q == CNT_ONE) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      color_q   <= '0;
      pix_q     <= '0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      color_q   <= color_d;
      pix_q     <= pix_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  gpu_cursor #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W)
  ) u_cursor (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .load   (cur_load),
    .load_x (cur_x),
    .load_y (cur_y),
    .advance(cur_advance),
    .addr   (o_fb_addr)
  );

  assign o_busy    = (state_q == WRITE);
  assign o_fb_we   = (state_q == WRITE);
  assign o_fb_data = pix_q;
  assign o_error   = error_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_instruction_executor.sv
// Self-checking bench: a coordinate-level model predicts every framebuffer write;
// a small-resolution second instance exercises the full-screen CLEAR path.
module tb_instruction_executor;

  localparam int H = 640;
  localparam int V = 480;
  localparam int SH = 8;
  localparam int SV = 4;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_instruction;
  logic        i_instruction_ready;
  logic        o_busy;
  logic        o_fb_we;
  logic [18:0] o_fb_addr;
  logic [7:0]  o_fb_data;
  logic        i_fb_ack;
  logic        o_error;
  logic        o_overrun;

  logic [31:0] s_instruction;
  logic        s_ready;
  logic        s_busy;
  logic        s_we;
  logic [4:0]  s_addr;
  logic [7:0]  s_data;
  logic        s_error;
  logic        s_overrun;

  instruction_executor dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_instruction      (i_instruction),
    .i_instruction_ready(i_instruction_ready),
    .o_busy             (o_busy),
    .o_fb_we            (o_fb_we),
    .o_fb_addr          (o_fb_addr),
    .o_fb_data          (o_fb_data),
    .i_fb_ack           (i_fb_ack),
    .o_error            (o_error),
    .o_overrun          (o_overrun)
  );

  instruction_executor #(.H_RES(SH), .V_RES(SV), .ADDR_W(5), .COLOR_W(8)) dut_small (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_instruction      (s_instruction),
    .i_instruction_ready(s_ready),
    .o_busy             (s_busy),
    .o_fb_we            (s_we),
    .o_fb_addr          (s_addr),
    .o_fb_data          (s_data),
    .i_fb_ack           (1'b1),
    .o_error            (s_error),
    .o_overrun          (s_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Model state
  wr_t exp_q[$];
  int  rd_idx = 0;
  int  m_x, m_y;
  logic [7:0] m_color;
  logic m_err, m_ovr;

  // Observed DUT activity
  int dut_busy_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] log_addr[$];
  logic [7:0]  log_data[$];
  logic [31:0] s_log_addr[$];
  logic [7:0]  s_log_data[$];

  int stall;
  int phase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] logged_addr(input int i);
    return (i < log_addr.size()) ? log_addr[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [7:0] logged_data(input int i);
    return (i < log_data.size()) ? log_data[i] : 8'hEE;
  endfunction

  function automatic logic [23:0] cur(input int x, input int y);
    logic [11:0] xs, ys;
    xs = 12'(x);
    ys = 12'(y);
    return {ys, xs};
  endfunction

  // Compare process: DUT vs model on every cycle, sampled mid-cycle.
  always @(negedge i_clk) begin : compare
    logic pend;
    if (i_reset) begin
      rd_idx = exp_q.size();
    end else begin
      pend = (exp_q.size() > rd_idx);
      check("busy", 32'(o_busy), 32'(pend));
      check("fb_we", 32'(o_fb_we), 32'(pend));
      check("error", 32'(o_error), 32'(m_err));
      check("overrun", 32'(o_overrun), 32'(m_ovr));
      if (pend) begin
        check("fb_addr", 32'(o_fb_addr), exp_q[rd_idx].addr);
        check("fb_data", 32'(o_fb_data), 32'(exp_q[rd_idx].data));
        if (i_fb_ack) rd_idx++;
      end
      if (o_busy) dut_busy_cnt++;
      if (o_fb_we && i_fb_ack) begin
        wr_cnt++;
        log_addr.push_back(32'(o_fb_addr));
        log_data.push_back(o_fb_data);
      end
      if (s_we) begin
        s_log_addr.push_back(32'(s_addr));
        s_log_data.push_back(s_data);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    i_instruction_ready = 1'b0;
    s_ready = 1'b0;
    i_fb_ack = (stall == 0) ? 1'b1 : ((phase % (stall + 1)) == stall);
    phase++;
  endtask

  task automatic model_put(input logic [7:0] data);
    wr_t w;
    w.addr = 32'(m_y * H + m_x);
    w.data = data;
    exp_q.push_back(w);
    m_x++;
    if (m_x == H) begin
      m_x = 0;
      m_y++;
      if (m_y == V) m_y = 0;
    end
  endtask

  task automatic model_apply(input logic [7:0] op, input logic [23:0] args);
    int x, y, n;
    case (op)
      8'h00: ;
      8'h01: m_color = args[7:0];
      8'h02: begin
        x = int'(args[11:0]);
        y = int'(args[23:12]);
        if (x >= H || y >= V) m_err = 1'b1;
        else begin
          m_x = x;
          m_y = y;
        end
      end
      8'h03: model_put(m_color);
      8'h04: begin
        n = int'(args[15:0]);
        for (int i = 0; i < n; i++) model_put(m_color);
      end
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic model_clear();
    m_x = 0; m_y = 0; m_color = 8'h00; m_err = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [23:0] args);
    logic was_busy;
    was_busy = (exp_q.size() > rd_idx);
    i_instruction = {args, op};
    i_instruction_ready = 1'b1;
    phase = 0;
    tick();
    if (was_busy) m_ovr = 1'b1;
    else model_apply(op, args);
  endtask

  task automatic s_issue(input logic [7:0] op, input logic [23:0] args);
    s_instruction = {args, op};
    s_ready = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (exp_q.size() > rd_idx && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() > rd_idx) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic s_wait_idle(input int budget);
    int n = 0;
    while (s_busy && n < budget) begin
      tick();
      n++;
    end
    if (s_busy) check("small_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    model_clear();
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    int base, bbase, wbase;
    i_reset = 1'b1;
    i_instruction = '0;
    i_instruction_ready = 1'b0;
    i_fb_ack = 1'b0;
    s_instruction = '0;
    s_ready = 1'b0;
    stall = 0;
    phase = 0;
    model_clear();
    do_reset();

    // Reset state
    check("rst_busy", 32'(o_busy), 0);
    check("rst_we", 32'(o_fb_we), 0);
    check("rst_addr", 32'(o_fb_addr), 0);
    check("rst_data", 32'(o_fb_data), 0);
    check("rst_error", 32'(o_error), 0);
    check("rst_overrun", 32'(o_overrun), 0);

    // Single pixel, register ops immediately followed by a pixel op
    base = log_addr.size();
    bbase = dut_busy_cnt;
    issue(8'h01, 24'h00002A);
    issue(8'h02, cur(5, 2));
    issue(8'h03, 24'h0);
    wait_idle(20);
    check("put_count", 32'(log_addr.size() - base), 1);
    check("put_addr", logged_addr(base), 1285);
    check("put_data", 32'(logged_data(base)), 32'h2A);
    check("put_busy_cycles", 32'(dut_busy_cnt - bbase), 1);

    // Run across the frame wrap, then confirm the cursor landed on (1,0)
    base = log_addr.size();
    issue(8'h02, cur(638, 479));
    issue(8'h04, 24'd3);
    wait_idle(20);
    check("wrap_addr0", logged_addr(base), 307198);
    check("wrap_addr1", logged_addr(base + 1), 307199);
    check("wrap_addr2", logged_addr(base + 2), 0);
    issue(8'h03, 24'h0);
    wait_idle(20);
    check("wrap_cursor", logged_addr(base + 3), 1);

    // Stalled handshake: three idle-ack cycles before each ack
    stall = 3;
    issue(8'h01, 24'h000033);
    issue(8'h02, cur(10, 0));
    base = log_addr.size();
    bbase = dut_busy_cnt;
    wbase = wr_cnt;
    issue(8'h04, 24'd4);
    wait_idle(100);
    stall = 0;
    tick();
    check("stall_writes", 32'(wr_cnt - wbase), 4);
    check("stall_busy_cycles", 32'(dut_busy_cnt - bbase), 16);
    check("stall_last_addr", logged_addr(base + 3), 13);
    check("stall_last_data", 32'(logged_data(base + 3)), 32'h33);

    // Zero-length run is register-only
    wbase = wr_cnt;
    issue(8'h04, 24'd0);
    check("run0_busy", 32'(o_busy), 0);
    tick();
    check("run0_writes", 32'(wr_cnt - wbase), 0);

    // Overrun during a run, then a back-to-back pixel op
    wbase = wr_cnt;
    issue(8'h04, 24'd8);
    tick(); tick(); tick();
    issue(8'h03, 24'h0);
    wait_idle(50);
    check("overrun_writes", 32'(wr_cnt - wbase), 8);
    check("overrun_flag", 32'(o_overrun), 1);
    issue(8'h03, 24'h0);
    wait_idle(20);
    check("b2b_writes", 32'(wr_cnt - wbase), 9);

    // Out-of-range cursor and unknown opcode
    do_reset();
    issue(8'h02, cur(640, 0));
    check("cursor_x_err", 32'(o_error), 1);
    base = log_addr.size();
    issue(8'h03, 24'h0);
    wait_idle(20);
    check("cursor_ignored", logged_addr(base), 0);
    do_reset();
    issue(8'h02, cur(0, 480));
    check("cursor_y_err", 32'(o_error), 1);
    do_reset();
    check("err_cleared", 32'(o_error), 0);
    issue(8'h7F, 24'h0);
    check("unknown_err", 32'(o_error), 1);

    // Reset in the middle of a run
    do_reset();
    issue(8'h01, 24'h000077);
    issue(8'h02, cur(100, 100));
    issue(8'h04, 24'd20);
    tick(); tick(); tick(); tick();
    i_reset = 1'b1;
    model_clear();
    #1;
    check("midrst_we", 32'(o_fb_we), 0);
    check("midrst_busy", 32'(o_busy), 0);
    tick();
    tick();
    i_reset = 1'b0;
    base = log_addr.size();
    issue(8'h03, 24'h0);
    wait_idle(20);
    check("midrst_addr", logged_addr(base), 0);
    check("midrst_data", 32'(logged_data(base)), 0);

    // Full-screen clear on the small-resolution instance
    s_issue(8'h01, 24'h000055);
    s_issue(8'h02, cur(3, 2));
    base = s_log_addr.size();
    s_issue(8'h05, 24'h000011);
    s_wait_idle(200);
`ifdef EXECUTOR_CLEAR_EN
    check("clear_count", 32'(s_log_addr.size() - base), SH * SV);
    for (int i = 0; i < SH * SV; i++) begin
      if (base + i < s_log_addr.size()) begin
        check("clear_addr", s_log_addr[base + i], 32'(i));
        check("clear_data", 32'(s_log_data[base + i]), 32'h11);
      end
    end
    check("clear_error", 32'(s_error), 0);
    base = s_log_addr.size();
    s_issue(8'h03, 24'h0);
    s_wait_idle(20);
    check("clear_cursor", (base < s_log_addr.size()) ? s_log_addr[base] : 32'hFFFF_FFFF, 0);
    check("clear_keeps_color", (base < s_log_data.size()) ? 32'(s_log_data[base]) : 32'hEE, 32'h55);
`else
    check("noclear_count", 32'(s_log_addr.size() - base), 0);
    check("noclear_error", 32'(s_error), 1);
    base = s_log_addr.size();
    s_issue(8'h03, 24'h0);
    s_wait_idle(20);
    check("noclear_cursor", (base < s_log_addr.size()) ? s_log_addr[base] : 32'hFFFF_FFFF, 19);
    check("noclear_color", (base < s_log_data.size()) ? 32'(s_log_data[base]) : 32'hEE, 32'h55);
`endif
    check("small_overrun", 32'(s_overrun), 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
